// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the 4-stage pipeline datapath (master) and the hazard controller (slave).
// Carries stage occupancy and register indices in, and the stall/flush/forwarding controls and state out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs_a;
    logic [REG_AW-1:0] id_rs_b;
    logic              id_use_a;
    logic              id_use_b;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr;
    logic              ex_load;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_wr;
    logic              br_taken;
    logic              halt_req;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
        output ex_valid, ex_rd, ex_wr, ex_load,
        output wb_valid, wb_rd, wb_wr, br_taken, halt_req,
        input  pc_en, ifid_en, ifid_flush, idex_bubble,
        input  fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
        input  ex_valid, ex_rd, ex_wr, ex_load,
        input  wb_valid, wb_rd, wb_wr, br_taken, halt_req,
        output pc_en, ifid_en, ifid_flush, idex_bubble,
        output fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch kill, halt/drain and operand forwarding.
// PIPE_PERF_CNT_EN enables the saturating stall/flush performance counters (tied to zero otherwise).
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_LDSTALL = 2'b01;
    localparam logic [1:0] ST_HALT    = 2'b10;
    localparam logic [2:0] LAT_M1     = 3'(LOAD_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       haz_s;
    logic       pc_en_s, ifid_en_s, ifid_flush_s, idex_bubble_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic use_x);
        logic [1:0] sel;
        if (use_x && bus.ex_valid && bus.ex_wr && !bus.ex_load &&
            (bus.ex_rd != {REG_AW{1'b0}}) && (bus.ex_rd == rs)) begin
            sel = 2'b01;
        end else if (use_x && bus.wb_valid && bus.wb_wr &&
                     (bus.wb_rd != {REG_AW{1'b0}}) && (bus.wb_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use hazard and forwarding selects, evaluated in every state
    always_comb begin
        haz_s = bus.ex_valid && bus.ex_wr && bus.ex_load && (bus.ex_rd != {REG_AW{1'b0}}) &&
                bus.id_valid && ((bus.id_use_a && (bus.id_rs_a == bus.ex_rd)) ||
                                 (bus.id_use_b && (bus.id_rs_b == bus.ex_rd)));
        fwd_a_s = fwd_sel(bus.id_rs_a, bus.id_use_a);
        fwd_b_s = fwd_sel(bus.id_rs_b, bus.id_use_b);
    end

    // Next-state and front-end control; a taken branch overrides every state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b1;
        if (bus.br_taken) begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            ifid_flush_s = 1'b1;
            if (state_q != ST_HALT) begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end else begin
                state_d = ST_HALT;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (haz_s) begin
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LDSTALL;
                            cnt_d   = LAT_M1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        pc_en_s       = 1'b1;
                        ifid_en_s     = 1'b1;
                        idex_bubble_s = 1'b0;
                        if (bus.halt_req) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_LDSTALL: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LDSTALL;
                    end
                end
                ST_HALT: begin
                    if (!bus.halt_req) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and stall-countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces a safe stalled/flushed front end regardless of inputs
    always_comb begin
        if (!rst_n) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.fwd_a       = 2'b00;
            bus.fwd_b       = 2'b00;
        end else begin
            bus.pc_en       = pc_en_s;
            bus.ifid_en     = ifid_en_s;
            bus.ifid_flush  = ifid_flush_s;
            bus.idex_bubble = idex_bubble_s;
            bus.fwd_a       = fwd_a_s;
            bus.fwd_b       = fwd_b_s;
        end
    end

    assign bus.state = state_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc_s, flush_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    assign stall_inc_s = !bus.br_taken &&
                         (((state_q == ST_RUN) && haz_s) || (state_q == ST_LDSTALL));
    assign flush_inc_s = bus.br_taken;

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_inc_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
            flush_cnt_q <= flush_inc_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: five instances (LOAD_LAT 1..4, plus a 2-bit-counter instance) share one
// stimulus stream and are checked every cycle against a cycle-level model of the sequencing rules.
module tb_pipe_hazard_ctrl;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       id_valid, id_use_a, id_use_b, ex_valid, ex_wr, ex_load;
    logic       wb_valid, wb_wr, br_taken, halt_req;
    logic [2:0] id_rs_a, id_rs_b, ex_rd, wb_rd;

    logic [9:0] obs_ctl  [N];
    logic [7:0] obs_scnt [N];
    logic [7:0] obs_fcnt [N];

    int tests = 0;
    int fails = 0;

    int lat  [N] = '{1, 2, 3, 4, 1};
    int cmax [N] = '{255, 255, 255, 255, 3};
    int left [N];
    bit halted [N];
    int scnt [N];
    int fcnt [N];

    genvar g;
    for (g = 0; g < N; g++) begin : g_dut
        localparam int LL = (g == 4) ? 1 : g + 1;
        localparam int CW = (g == 4) ? 2 : 8;
        pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(CW)) bus ();
        assign bus.id_valid = id_valid;
        assign bus.id_rs_a  = id_rs_a;
        assign bus.id_rs_b  = id_rs_b;
        assign bus.id_use_a = id_use_a;
        assign bus.id_use_b = id_use_b;
        assign bus.ex_valid = ex_valid;
        assign bus.ex_rd    = ex_rd;
        assign bus.ex_wr    = ex_wr;
        assign bus.ex_load  = ex_load;
        assign bus.wb_valid = wb_valid;
        assign bus.wb_rd    = wb_rd;
        assign bus.wb_wr    = wb_wr;
        assign bus.br_taken = br_taken;
        assign bus.halt_req = halt_req;
        pipe_hazard_ctrl #(.REG_AW(3), .LOAD_LAT(LL), .CNT_W(CW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign obs_ctl[g]  = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                              bus.fwd_a, bus.fwd_b, bus.state};
        assign obs_scnt[g] = 8'(bus.stall_cnt);
        assign obs_fcnt[g] = 8'(bus.flush_cnt);
    end

    function automatic logic [1:0] exp_fwd(input logic [2:0] rs, input logic u);
        if (u && ex_valid && ex_wr && !ex_load && ex_rd != 3'd0 && ex_rd == rs) return 2'b01;
        if (u && wb_valid && wb_wr && wb_rd != 3'd0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit exp_haz();
        return ex_valid && ex_wr && ex_load && ex_rd != 3'd0 && id_valid &&
               ((id_use_a && id_rs_a == ex_rd) || (id_use_b && id_rs_b == ex_rd));
    endfunction

    task automatic chk(input string tag, input int i, input logic [9:0] obs, input logic [9:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            left[i] = 0; halted[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_use_a = 1'b0; id_use_b = 1'b0; id_rs_a = 3'd0; id_rs_b = 3'd0;
        ex_valid = 1'b0; ex_wr = 1'b0; ex_load = 1'b0; ex_rd = 3'd0;
        wb_valid = 1'b0; wb_wr = 1'b0; wb_rd = 3'd0; br_taken = 1'b0; halt_req = 1'b0;
    endtask

    task automatic load_use();
        idle();
        id_valid = 1'b1; id_use_a = 1'b1; id_rs_a = 3'd3;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_load = 1'b1; ex_rd = 3'd3;
    endtask

    // Called at a falling edge with inputs applied; checks this cycle and advances the model.
    task automatic step(input string tag);
        logic [3:0] ctl;
        logic [1:0] st;
        int es, ef;
        #1;
        for (int i = 0; i < N; i++) begin
            st = halted[i] ? 2'd2 : ((left[i] > 0) ? 2'd1 : 2'd0);
`ifdef PIPE_PERF_CNT_EN
            es = scnt[i]; ef = fcnt[i];
`else
            es = 0; ef = 0;
`endif
            if (br_taken) begin
                ctl = 4'b1111;
                if (!halted[i]) left[i] = 0;
                if (fcnt[i] < cmax[i]) fcnt[i]++;
            end else if (left[i] > 0) begin
                ctl = 4'b0001;
                left[i]--;
                if (scnt[i] < cmax[i]) scnt[i]++;
            end else if (halted[i]) begin
                ctl = 4'b0001;
                if (!halt_req) halted[i] = 1'b0;
            end else if (exp_haz()) begin
                ctl = 4'b0001;
                left[i] = lat[i] - 1;
                if (scnt[i] < cmax[i]) scnt[i]++;
            end else begin
                ctl = 4'b1100;
                if (halt_req) halted[i] = 1'b1;
            end
            chk(tag, i, obs_ctl[i], {ctl, exp_fwd(id_rs_a, id_use_a), exp_fwd(id_rs_b, id_use_b), st});
            chk({tag, "_stallcnt"}, i, {2'b00, obs_scnt[i]}, 10'(es));
            chk({tag, "_flushcnt"}, i, {2'b00, obs_fcnt[i]}, 10'(ef));
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        #1;
        for (int i = 0; i < N; i++) begin
            chk(tag, i, obs_ctl[i], {4'b0011, 2'b00, 2'b00, 2'b00});
            chk({tag, "_stallcnt"}, i, {2'b00, obs_scnt[i]}, 10'd0);
            chk({tag, "_flushcnt"}, i, {2'b00, obs_fcnt[i]}, 10'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset with forwarding-matching inputs: selects must still read 00
        idle();
        ex_valid = 1'b1; ex_wr = 1'b1; ex_rd = 3'd5; id_rs_a = 3'd5; id_use_a = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        idle();
        step("post_reset");

        load_use();
        step("loaduse");
        idle();
        for (int k = 0; k < 5; k++) step("loaduse_drain");

        idle();
        id_valid = 1'b1; id_rs_b = 3'd5; id_use_b = 1'b1;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_rd = 3'd5;
        wb_valid = 1'b1; wb_wr = 1'b1; wb_rd = 3'd5;
        step("fwd_ex");
        ex_wr = 1'b0;
        step("fwd_wb");
        ex_wr = 1'b1; ex_rd = 3'd0; wb_rd = 3'd0;
        step("fwd_r0");
        ex_rd = 3'd5; wb_rd = 3'd5; ex_load = 1'b1;
        step("fwd_load_wb");
        wb_rd = 3'd2;
        step("fwd_load_none");
        idle();
        for (int k = 0; k < 5; k++) step("fwd_drain");

        load_use();
        step("br_haz");
        idle();
        step("br_stall1");
        br_taken = 1'b1;
        step("br_in_stall");
        idle();
        for (int k = 0; k < 4; k++) step("br_drain");

        halt_req = 1'b1;
        step("halt_enter");
        step("halt_hold");
        br_taken = 1'b1;
        step("halt_branch");
        br_taken = 1'b0; halt_req = 1'b0;
        step("halt_exit");
        step("halt_run");

        for (int h = 0; h < 5; h++) begin
            load_use();
            step("sat_haz");
            idle();
            for (int k = 0; k < 4; k++) step("sat_gap");
        end

        // Reset asserted while the LOAD_LAT=3 instance is mid-stall
        load_use();
        step("rst_haz");
        idle();
        rst_n = 1'b0;
        chk_reset("reset_mid_stall");
        model_reset();
        rst_n = 1'b1;
        step("rst_release");

        for (int n = 0; n < 1500; n++) begin
            id_valid = 1'($urandom_range(0, 1));
            id_use_a = 1'($urandom_range(0, 1));
            id_use_b = 1'($urandom_range(0, 1));
            id_rs_a  = 3'($urandom_range(0, 3));
            id_rs_b  = 3'($urandom_range(0, 3));
            ex_valid = 1'($urandom_range(0, 1));
            ex_wr    = 1'($urandom_range(0, 1));
            ex_load  = 1'($urandom_range(0, 1));
            ex_rd    = 3'($urandom_range(0, 3));
            wb_valid = 1'($urandom_range(0, 1));
            wb_wr    = 1'($urandom_range(0, 1));
            wb_rd    = 3'($urandom_range(0, 3));
            br_taken = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
